// File: rtl/button_event_decoder_if.sv
// Signal bundle between the debounced button source and the event decoder.
// There is no handshake: btn_in is a level, every other decoder output is a registered level or a one-cycle pulse.
interface button_event_decoder_if;
  logic       btn_in;
  logic       btn_state;
  logic       press_pulse;
  logic       release_pulse;
  logic       single_click;
  logic       double_click;
  logic       long_press;
  logic [2:0] dbg_state;

  modport slave (
    input  btn_in,
    output btn_state, press_pulse, release_pulse,
    output single_click, double_click, long_press, dbg_state
  );

  modport master (
    output btn_in,
    input  btn_state, press_pulse, release_pulse,
    input  single_click, double_click, long_press, dbg_state
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into press/release/single/double/long-press pulses.
// Timing uses a ms prescaler that restarts on every state change.
module button_event_decoder #(
  parameter int TICK_DIV  = 50000,
  parameter int TICK_W    = 16,
  parameter int MS_W      = 12,
  parameter int LONG_MS   = 1000,
  parameter int DCLICK_MS = 300
) (
  input  logic                  clk,
  input  logic                  reset_n,
  button_event_decoder_if.slave btn
);

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_e;

  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [MS_W-1:0]   LONG_LAST   = MS_W'(LONG_MS - 1);
  localparam logic [MS_W-1:0]   DCLICK_LAST = MS_W'(DCLICK_MS - 1);

  state_e              state_q, state_d;
  logic                btn_q;
  logic [TICK_W-1:0]   presc_q, presc_d;
  logic [MS_W-1:0]     ms_q, ms_d;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                single_q, single_d;
  logic                double_q, double_d;
  logic                long_q, long_d;

  logic rise, fall, tick_end, long_to, dclick_to;

  assign rise      = btn.btn_in & ~btn_q;
  assign fall      = ~btn.btn_in & btn_q;
  assign tick_end  = (presc_q == TICK_LAST);
  assign long_to   = tick_end && (ms_q == LONG_LAST);
  assign dclick_to = tick_end && (ms_q == DCLICK_LAST);

  // Edges are checked before timeouts so an edge wins a same-cycle race.
  always_comb begin
    state_d   = state_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    single_d  = 1'b0;
    double_d  = 1'b0;
    long_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d   = WAIT_SECOND;
          release_d = 1'b1;
        end else if (long_to) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
      WAIT_SECOND: begin
        if (rise) begin
          state_d = SECOND_PRESSED;
          press_d = 1'b1;
        end else if (dclick_to) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end
      end
      SECOND_PRESSED: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          double_d  = 1'b1;
        end else if (long_to) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters run only while a timed state is held; any transition restarts them.
  always_comb begin
    presc_d = '0;
    ms_d    = '0;
    if ((state_d == state_q) &&
        (state_q inside {PRESSED, WAIT_SECOND, SECOND_PRESSED})) begin
      if (tick_end) begin
        presc_d = '0;
        ms_d    = ms_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
        ms_d    = ms_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      btn_q     <= 1'b0;
      presc_q   <= '0;
      ms_q      <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      single_q  <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn.btn_in;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      press_q   <= press_d;
      release_q <= release_d;
      single_q  <= single_d;
      double_q  <= double_d;
      long_q    <= long_d;
    end
  end

  assign btn.btn_state     = btn_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.single_click  = single_q;
  assign btn.double_click  = double_q;
  assign btn.long_press    = long_q;
  assign btn.dbg_state     = state_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with TICK_DIV=4, LONG_MS=10, DCLICK_MS=5.
// Pulses are logged as (cycle offset, event code) and compared to hand-computed lists.
module tb_button_event_decoder;

  localparam int EV_PRESS   = 1;
  localparam int EV_RELEASE = 2;
  localparam int EV_SINGLE  = 3;
  localparam int EV_DOUBLE  = 4;
  localparam int EV_LONG    = 5;

  logic clk;
  logic reset_n;
  int   cyc;
  int   t0;
  int   n_total;
  int   n_bad;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  button_event_decoder_if btn_if ();

  button_event_decoder #(
    .TICK_DIV (4),
    .TICK_W   (16),
    .MS_W     (12),
    .LONG_MS  (10),
    .DCLICK_MS(5)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .btn    (btn_if.slave)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (btn_if.press_pulse)   obs_q.push_back({16'(cyc - t0), 16'(EV_PRESS)});
      if (btn_if.release_pulse) obs_q.push_back({16'(cyc - t0), 16'(EV_RELEASE)});
      if (btn_if.single_click)  obs_q.push_back({16'(cyc - t0), 16'(EV_SINGLE)});
      if (btn_if.double_click)  obs_q.push_back({16'(cyc - t0), 16'(EV_DOUBLE)});
      if (btn_if.long_press)    obs_q.push_back({16'(cyc - t0), 16'(EV_LONG)});
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // driver tasks
  task automatic hold(input logic v, input int n);
    btn_if.btn_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_test();
    obs_q.delete();
    exp_q.delete();
    t0 = cyc;
  endtask

  task automatic expect_ev(input int off, input int code);
    exp_q.push_back({16'(off), 16'(code)});
  endtask

  // scoreboard compare
  task automatic end_test(input string tag);
    check_val({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs_q.size())
        check_val($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_btn_state"}, 32'(btn_if.btn_state),     32'd0);
    check_val({tag, "_press"},     32'(btn_if.press_pulse),   32'd0);
    check_val({tag, "_release"},   32'(btn_if.release_pulse), 32'd0);
    check_val({tag, "_single"},    32'(btn_if.single_click),  32'd0);
    check_val({tag, "_double"},    32'(btn_if.double_click),  32'd0);
    check_val({tag, "_long"},      32'(btn_if.long_press),    32'd0);
    check_val({tag, "_state"},     32'(btn_if.dbg_state),     32'd0);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    t0      = 0;
    reset_n = 1'b0;
    btn_if.btn_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    reset_n = 1'b1;
    hold(1'b0, 2);

    // single click
    begin_test();
    hold(1'b1, 8);
    hold(1'b0, 40);
    expect_ev(1, EV_PRESS);
    expect_ev(9, EV_RELEASE);
    expect_ev(29, EV_SINGLE);
    end_test("single");

    // double click
    begin_test();
    hold(1'b1, 8);
    hold(1'b0, 6);
    hold(1'b1, 8);
    hold(1'b0, 40);
    expect_ev(1, EV_PRESS);
    expect_ev(9, EV_RELEASE);
    expect_ev(15, EV_PRESS);
    expect_ev(23, EV_RELEASE);
    expect_ev(23, EV_DOUBLE);
    end_test("double");

    // long press
    begin_test();
    hold(1'b1, 45);
    check_val("long_state_held", 32'(btn_if.dbg_state), 32'd2);
    check_val("long_btn_state", 32'(btn_if.btn_state), 32'd1);
    hold(1'b1, 15);
    hold(1'b0, 40);
    expect_ev(1, EV_PRESS);
    expect_ev(41, EV_LONG);
    expect_ev(61, EV_RELEASE);
    end_test("long");

    // fall on the same edge as the long timeout
    begin_test();
    hold(1'b1, 40);
    hold(1'b0, 40);
    expect_ev(1, EV_PRESS);
    expect_ev(41, EV_RELEASE);
    expect_ev(61, EV_SINGLE);
    end_test("edge_vs_long");

    // second press held into a long press
    begin_test();
    hold(1'b1, 8);
    hold(1'b0, 6);
    hold(1'b1, 50);
    hold(1'b0, 40);
    expect_ev(1, EV_PRESS);
    expect_ev(9, EV_RELEASE);
    expect_ev(15, EV_PRESS);
    expect_ev(55, EV_LONG);
    expect_ev(65, EV_RELEASE);
    end_test("second_long");

    // reset while waiting for a second press
    begin_test();
    hold(1'b1, 8);
    hold(1'b0, 6);
    check_val("wait_state", 32'(btn_if.dbg_state), 32'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check_quiet("async_rst");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold(1'b0, 40);
    expect_ev(1, EV_PRESS);
    expect_ev(9, EV_RELEASE);
    end_test("mid_reset");

    // normal click after the reset
    begin_test();
    hold(1'b1, 8);
    hold(1'b0, 40);
    expect_ev(1, EV_PRESS);
    expect_ev(9, EV_RELEASE);
    expect_ev(29, EV_SINGLE);
    end_test("post_reset");

    // button already high when reset is released
    begin_test();
    reset_n = 1'b0;
    hold(1'b1, 2);
    reset_n = 1'b1;
    hold(1'b1, 5);
    hold(1'b0, 40);
    expect_ev(3, EV_PRESS);
    expect_ev(8, EV_RELEASE);
    expect_ev(28, EV_SINGLE);
    end_test("high_at_reset");

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced, positive-polarity button level produced by the debouncer stage.
- Classifies each button interaction into single-cycle event pulses: press, release, single click, double click and long press.
- Sits between the debouncer and the GPIO/interrupt register logic, on the same system clock.
- Timing is derived from an internal millisecond prescaler.

Parameters:
- TICK_DIV, 50000, clock cycles per ms tick (1 ms at 50 MHz); legal range ≥1.
- TICK_W, 16, prescaler width; 2^TICK_W ≥ TICK_DIV.
- MS_W, 12, ms counter width.
- LONG_MS, 1000, hold time in ms that qualifies as a long press; 1 ≤ LONG_MS < 2^MS_W.
- DCLICK_MS, 300, ms window after the first release in which a second press makes a double click; 1 ≤ DCLICK_MS < 2^MS_W.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- btn_in  input  1  debounced button level, 1 = pressed, synchronous to clk
- btn_state  output  1  registered button level
- press_pulse  output  1  one-cycle pulse on press
- release_pulse  output  1  one-cycle pulse on release
- single_click  output  1  one-cycle pulse, click with no second press in window
- double_click  output  1  one-cycle pulse, on release of second press
- long_press  output  1  one-cycle pulse, hold reached LONG_MS

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0, btn_q=0, state IDLE, prescaler=0, ms_cnt=0. The first rising edge after release of reset evaluates normally.
- Edge detection:
  - btn_q registers btn_in; rise = btn_in & ~btn_q, fall = ~btn_in & btn_q.
  - FSM and all outputs are registered. An event pulse is high for exactly one clk, during the cycle after the edge at which btn_in first differs from btn_q.
  - btn_state equals btn_q.
- Timer:
  - Prescaler counts 0..TICK_DIV-1 and wraps. ms_cnt increments on the wrap.
  - Both counters clear to 0 on every state transition. Both are held at 0 in IDLE and LONG_HELD.
  - Timeout(LIMIT) is true on the cycle where prescaler==TICK_DIV-1 and ms_cnt==LIMIT-1, i.e. exactly LIMIT*TICK_DIV cycles after state entry. Counters never wrap.
- States and transitions:
  - IDLE:
    - rise → PRESSED, press_pulse.
  - PRESSED:
    - fall → WAIT_SECOND, release_pulse.
    - else Timeout(LONG_MS) → LONG_HELD, long_press.
  - LONG_HELD:
    - fall → IDLE, release_pulse. No click event is generated.
  - WAIT_SECOND:
    - rise → SECOND_PRESSED, press_pulse.
    - else Timeout(DCLICK_MS) → IDLE, single_click.
  - SECOND_PRESSED:
    - fall → IDLE, release_pulse and double_click in the same cycle.
    - else Timeout(LONG_MS) → LONG_HELD, long_press. The pending click is discarded; no single_click or double_click is generated.
- Simultaneous events: an edge of btn_in takes priority over a timeout in the same cycle (fall beats long timeout; rise beats double-click window expiry).
- Every pulse output drops to 0 on the cycle after it is asserted. press_pulse and release_pulse never coincide.
- Reset mid-operation: any pending click is discarded and no event is emitted. After reset release, a btn_in that is already high produces press_pulse on the first cycle, since btn_q=0.

Test Plan:
Bench parameters: TICK_DIV=4, LONG_MS=10 (40 cycles), DCLICK_MS=5 (20 cycles).
- Single click: btn_in high 8 cycles, then low.
  - press_pulse 1 cycle after the rise; release_pulse 1 cycle after the fall.
  - single_click exactly 20 cycles after release_pulse; no other events.
- Double click: high 8, low 6, high 8, low.
  - press_pulse ×2; release_pulse ×2.
  - double_click coincides with the second release_pulse; single_click never asserted.
- Long press: high 60 cycles, then low.
  - long_press exactly 40 cycles after press_pulse; release_pulse on the fall.
  - No single_click or double_click.
- Boundary: fall lands on the exact cycle Timeout(LONG_MS) would fire.
  - release_pulse asserted, long_press not asserted; single_click follows 20 cycles later.
- Second press held 50 cycles:
  - long_press 40 cycles after the second press_pulse; release_pulse on the fall.
  - No double_click or single_click.
- Reset: assert reset_n=0 for 3 cycles midway through WAIT_SECOND.
  - All outputs 0 immediately (asynchronous); no single_click afterwards.
  - A later click decodes normally.
